// File: rtl/lc3_mem_arbiter_pkg.sv
// lc3_mem_pkg: shared types and constants for the LC3 memory arbiter.
// States, requester ids, bus direction codes and default latency.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        PORT_F,
        PORT_D
    } port_id_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    localparam int LC3_MEM_LAT = 2;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// lc3_mem_arbiter_if: single-port LC3 memory bus.
// master = arbiter side, slave = memory model side.
interface lc3_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          mem_en;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (
        output mem_en, mem_rw, mem_addr, mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_en, mem_rw, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/lc3_arb_pick.sv
// lc3_arb_pick: combinational grant decision for the F and D requesters.
// LC3_ARB_RR_EN selects round-robin on contention; default is D over F.
module lc3_arb_pick
    import lc3_mem_pkg::*;
(
    input  logic     f_req,
    input  logic     d_req,
    input  port_id_t last_grant,
    output logic     grant_valid,
    output port_id_t grant_id
);

    port_id_t both_pick;

`ifdef LC3_ARB_RR_EN
    assign both_pick = (last_grant == PORT_D) ? PORT_F : PORT_D;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign both_pick = PORT_D;
`endif

    // Pick the winner among the pending requesters.
    always_comb begin
        grant_valid = f_req | d_req;
        grant_id    = PORT_F;
        unique case (1'b1)
            (d_req & ~f_req): grant_id = PORT_D;
            (f_req & ~d_req): grant_id = PORT_F;
            (f_req &  d_req): grant_id = both_pick;
            default:          grant_id = PORT_F;
        endcase
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the LC3 memory bus between fetch (F) and data (D).
// Optional macro LC3_ARB_RR_EN enables round-robin arbitration in lc3_arb_pick.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int MEM_LAT = LC3_MEM_LAT,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    lc3_mem_arbiter_if.master mem,
    output logic          busy
);

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    port_id_t   win;
    port_id_t   last_grant;
    logic [3:0] cnt;
    logic       grant_valid;
    port_id_t   grant_id;

    lc3_arb_pick u_pick (
        .f_req       (f_req),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Arbitration FSM with registered bus, ack and read-data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            win          <= PORT_F;
            last_grant   <= PORT_F;
            cnt          <= '0;
            mem.mem_en   <= 1'b0;
            mem.mem_rw   <= MEM_RD;
            mem.mem_addr <= '0;
            mem.mem_din  <= '0;
            f_ack        <= 1'b0;
            d_ack        <= 1'b0;
            f_rdata      <= '0;
            d_rdata      <= '0;
            busy         <= 1'b0;
        end else begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        win        <= grant_id;
                        last_grant <= grant_id;
                        if (grant_id == PORT_D) begin
                            mem.mem_addr <= d_addr;
                            mem.mem_rw   <= d_rw;
                            mem.mem_din  <= d_wdata;
                        end else begin
                            mem.mem_addr <= f_addr;
                            mem.mem_rw   <= MEM_RD;
                            mem.mem_din  <= '0;
                        end
                        mem.mem_en <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= CNT_INIT;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        mem.mem_en <= 1'b0;
                        state      <= RESP;
                        if (win == PORT_D) begin
                            d_ack <= 1'b1;
                            if (mem.mem_rw == MEM_RD) begin
                                d_rdata <= mem.mem_dout;
                            end
                        end else begin
                            f_ack   <= 1'b1;
                            f_rdata <= mem.mem_dout;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: scoreboard bench for lc3_mem_arbiter.
// Main instance at MEM_LAT=2 plus MEM_LAT=1 and MEM_LAT=15 latency instances.
module tb_lc3_mem_arbiter;
    import lc3_mem_pkg::*;

    localparam int LAT = 2;

    typedef struct {
        logic [1:0]  acks;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req, d_rw;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic        f_ack, d_ack, busy;
    logic [15:0] f_rdata, d_rdata;

    logic        f1_req, f15_req;
    logic        f1_ack, f15_ack;
    logic [15:0] f1_rdata, f15_rdata;
    logic        u1_dack, u15_dack, u1_busy, u15_busy;
    logic [15:0] u1_drd, u15_drd;

    logic        pk_en;
    logic [15:0] pk_a, pk_d;
    logic [15:0] mem [0:65535];

    int          checks = 0;
    int          passed = 0;
    exp_t        sb[$];
    logic [15:0] exp_f = '0;
    logic [15:0] exp_d = '0;

    always #5 clk = ~clk;

    lc3_mem_arbiter_if #(.AW(16), .DW(16)) m ();
    lc3_mem_arbiter_if #(.AW(16), .DW(16)) m1 ();
    lc3_mem_arbiter_if #(.AW(16), .DW(16)) m15 ();

    assign m.mem_dout   = mem[m.mem_addr];
    assign m1.mem_dout  = m1.mem_addr ^ 16'h5555;
    assign m15.mem_dout = m15.mem_addr ^ 16'h5555;

    wire unused_tb = ^{m1.mem_en, m1.mem_rw, m1.mem_din, m15.mem_en,
                       m15.mem_rw, m15.mem_din, u1_dack, u15_dack,
                       u1_busy, u15_busy, u1_drd, u15_drd};

    // Memory model: preload port or bus writes.
    always @(posedge clk) begin
        if (pk_en) mem[pk_a] <= pk_d;
        else if (m.mem_en && m.mem_rw) mem[m.mem_addr] <= m.mem_din;
    end

    lc3_mem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .mem(m), .busy(busy)
    );

    lc3_mem_arbiter #(.MEM_LAT(1)) u_l1 (
        .clk(clk), .rst(rst),
        .f_req(f1_req), .f_addr(16'h1234), .f_ack(f1_ack), .f_rdata(f1_rdata),
        .d_req(1'b0), .d_rw(1'b0), .d_addr(16'h0), .d_wdata(16'h0),
        .d_ack(u1_dack), .d_rdata(u1_drd), .mem(m1), .busy(u1_busy)
    );

    lc3_mem_arbiter #(.MEM_LAT(15)) u_l15 (
        .clk(clk), .rst(rst),
        .f_req(f15_req), .f_addr(16'h1234), .f_ack(f15_ack), .f_rdata(f15_rdata),
        .d_req(1'b0), .d_rw(1'b0), .d_addr(16'h0), .d_wdata(16'h0),
        .d_ack(u15_dack), .d_rdata(u15_drd), .mem(m15), .busy(u15_busy)
    );

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        pk_en = 1'b1; pk_a = a; pk_d = d;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    // Waits for an ack on the main instance, recording bus activity.
    task automatic wait_ack(input int budget, output int lat,
                            output logic [1:0] acks, output int en_n,
                            output logic [15:0] a, output logic rw,
                            output logic [15:0] din, output logic stable);
        lat = -1; acks = 2'b00; en_n = 0; stable = 1'b1;
        a = '0; rw = 1'b0; din = '0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (m.mem_en) begin
                if (en_n == 0) begin
                    a = m.mem_addr; rw = m.mem_rw; din = m.mem_din;
                end else if (m.mem_addr !== a || m.mem_rw !== rw || m.mem_din !== din) begin
                    stable = 1'b0;
                end
                en_n++;
            end
            if (f_ack || d_ack) begin
                lat = n; acks = {d_ack, f_ack};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; f_req = 0; d_req = 0; d_rw = 0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        f1_req = 0; f15_req = 0; pk_en = 0; pk_a = '0; pk_d = '0;
        poke(16'h3000, 16'h1261);
        poke(16'h4000, 16'h5A5A);
        poke(16'h0000, 16'h0BAD);
        poke(16'hFFFF, 16'hABCD);
        poke(16'h4005, 16'h0000);
        checks++;
        if ({m.mem_en, m.mem_rw, f_ack, d_ack, busy} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {m.mem_en, m.mem_rw, f_ack, d_ack, busy});
        else passed++;
        checks++;
        if (m.mem_addr !== 16'h0 || m.mem_din !== 16'h0)
            $display("FAIL reset_bus: addr %h din %h want 0", m.mem_addr, m.mem_din);
        else passed++;
        checks++;
        if (f_rdata !== 16'h0 || d_rdata !== 16'h0)
            $display("FAIL reset_rdata: f %h d %h want 0", f_rdata, d_rdata);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_data_write();
        int lat, en_n; logic [1:0] acks; logic [15:0] a, din; logic rw, st;
        exp_t e;
        @(negedge clk);
        d_req = 1; d_rw = 1; d_addr = 16'h4005; d_wdata = 16'hBEEF;
        sb.push_back('{2'b10, exp_d});
        wait_ack(20, lat, acks, en_n, a, rw, din, st);
        d_req = 0; d_rw = 0;
        checks++;
        if (lat !== LAT + 1) $display("FAIL wr_latency: got %0d want %0d", lat, LAT + 1);
        else passed++;
        checks++;
        if (en_n !== LAT || a !== 16'h4005 || rw !== 1'b1 || din !== 16'hBEEF || st !== 1'b1)
            $display("FAIL wr_bus: en %0d addr %h rw %b din %h stable %b want %0d 4005 1 beef 1",
                     en_n, a, rw, din, st, LAT);
        else passed++;
        checks++;
        if (mem[16'h4005] !== 16'hBEEF) $display("FAIL wr_mem: got %h want beef", mem[16'h4005]);
        else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL wr_sb: scoreboard empty");
        else begin
            e = sb.pop_front();
            if ({acks, d_rdata} !== {e.acks, e.data})
                $display("FAIL wr_ack: got %b/%h want %b/%h", acks, d_rdata, e.acks, e.data);
            else passed++;
        end
    endtask

    task automatic test_single_fetch();
        int lat, en_n; logic [1:0] acks; logic [15:0] a, din; logic rw, st;
        exp_t e;
        @(negedge clk);
        f_req = 1; f_addr = 16'h3000;
        exp_f = 16'h1261;
        sb.push_back('{2'b01, exp_f});
        wait_ack(20, lat, acks, en_n, a, rw, din, st);
        f_req = 0;
        checks++;
        if (lat !== LAT + 1) $display("FAIL fetch_latency: got %0d want %0d", lat, LAT + 1);
        else passed++;
        checks++;
        if (en_n !== LAT || a !== 16'h3000 || rw !== 1'b0 || st !== 1'b1)
            $display("FAIL fetch_bus: en %0d addr %h rw %b stable %b want %0d 3000 0 1",
                     en_n, a, rw, st, LAT);
        else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL fetch_sb: scoreboard empty");
        else begin
            e = sb.pop_front();
            if ({acks, f_rdata} !== {e.acks, e.data})
                $display("FAIL fetch_ack: got %b/%h want %b/%h", acks, f_rdata, e.acks, e.data);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if ({f_ack, d_ack, busy, m.mem_en} !== 4'b0)
            $display("FAIL fetch_after: ack/busy/en got %b want 0000", {f_ack, d_ack, busy, m.mem_en});
        else passed++;
    endtask

    task automatic test_contention();
        int lat, en_n; logic [1:0] acks; logic [15:0] a, din; logic rw, st;
        exp_t e;
        @(negedge clk);
        f_req = 1; f_addr = 16'h3000;
        d_req = 1; d_rw = 0; d_addr = 16'h4000;
        exp_d = 16'h5A5A;
        sb.push_back('{2'b10, exp_d});
        sb.push_back('{2'b01, exp_f});
        wait_ack(20, lat, acks, en_n, a, rw, din, st);
        d_req = 0;
        checks++;
        if (sb.size() == 0) $display("FAIL cont_first_sb: scoreboard empty");
        else begin
            e = sb.pop_front();
            if ({acks, d_rdata} !== {e.acks, e.data})
                $display("FAIL cont_first: got %b/%h want %b/%h", acks, d_rdata, e.acks, e.data);
            else passed++;
        end
        wait_ack(20, lat, acks, en_n, a, rw, din, st);
        f_req = 0;
        checks++;
        if (lat !== LAT + 2) $display("FAIL cont_period: got %0d want %0d", lat, LAT + 2);
        else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL cont_second_sb: scoreboard empty");
        else begin
            e = sb.pop_front();
            if ({acks, f_rdata} !== {e.acks, e.data})
                $display("FAIL cont_second: got %b/%h want %b/%h", acks, f_rdata, e.acks, e.data);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, en_n; logic [1:0] acks; logic [15:0] a, din; logic rw, st;
        exp_t e;
        @(negedge clk);
        f_req = 1; f_addr = 16'h3000;
        d_req = 1; d_rw = 0; d_addr = 16'h4000;
        for (int i = 0; i < 4; i++) begin
`ifdef LC3_ARB_RR_EN
            if (i % 2 == 0) sb.push_back('{2'b10, exp_d});
            else sb.push_back('{2'b01, exp_f});
`else
            sb.push_back('{2'b10, exp_d});
`endif
        end
        for (int i = 0; i < 4; i++) begin
            wait_ack(20, lat, acks, en_n, a, rw, din, st);
            if (i == 3) begin
                f_req = 0; d_req = 0;
            end
            checks++;
            if (sb.size() == 0) $display("FAIL b2b_sb_%0d: scoreboard empty", i);
            else begin
                e = sb.pop_front();
                if (acks !== e.acks || (e.acks[1] ? d_rdata : f_rdata) !== e.data)
                    $display("FAIL b2b_grant_%0d: got %b want %b/%h", i, acks, e.acks, e.data);
                else passed++;
            end
        end
    endtask

    task automatic test_input_churn();
        int lat, en_n; logic [1:0] acks; logic [15:0] a, din; logic rw, st;
        exp_t e;
        @(negedge clk);
        d_req = 1; d_rw = 0; d_addr = 16'h4000;
        sb.push_back('{2'b10, exp_d});
        @(negedge clk);
        d_addr = 16'h0000; d_rw = 1; d_wdata = 16'h1111;
        wait_ack(20, lat, acks, en_n, a, rw, din, st);
        d_req = 0; d_rw = 0;
        checks++;
        if (a !== 16'h4000 || rw !== 1'b0 || st !== 1'b1)
            $display("FAIL churn_bus: addr %h rw %b stable %b want 4000 0 1", a, rw, st);
        else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL churn_sb: scoreboard empty");
        else begin
            e = sb.pop_front();
            if ({acks, d_rdata} !== {e.acks, e.data})
                $display("FAIL churn_ack: got %b/%h want %b/%h", acks, d_rdata, e.acks, e.data);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int lat, en_n, seen; logic [1:0] acks; logic [15:0] a, din; logic rw, st;
        exp_t e;
        @(negedge clk);
        d_req = 1; d_rw = 0; d_addr = 16'h4000;
        repeat (2) @(negedge clk);
        rst = 1; d_req = 0;
        @(negedge clk);
        rst = 0;
        exp_d = '0; exp_f = '0;
        checks++;
        if ({m.mem_en, busy, f_ack, d_ack} !== 4'b0)
            $display("FAIL rstmid_state: en/busy/acks got %b want 0000", {m.mem_en, busy, f_ack, d_ack});
        else passed++;
        checks++;
        if (d_rdata !== exp_d) $display("FAIL rstmid_rdata: got %h want %h", d_rdata, exp_d);
        else passed++;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (f_ack || d_ack || m.mem_en) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL rstmid_quiet: got %0d active cycles want 0", seen);
        else passed++;
        f_req = 1; f_addr = 16'hFFFF;
        exp_f = 16'hABCD;
        sb.push_back('{2'b01, exp_f});
        wait_ack(20, lat, acks, en_n, a, rw, din, st);
        f_req = 0;
        checks++;
        if (lat !== LAT + 1 || a !== 16'hFFFF)
            $display("FAIL rstmid_fresh: lat %0d addr %h want %0d ffff", lat, a, LAT + 1);
        else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL rstmid_sb: scoreboard empty");
        else begin
            e = sb.pop_front();
            if ({acks, f_rdata, d_rdata} !== {e.acks, e.data, exp_d})
                $display("FAIL rstmid_ack: got %b/%h/%h want %b/%h/%h",
                         acks, f_rdata, d_rdata, e.acks, e.data, exp_d);
            else passed++;
        end
    endtask

    task automatic test_latency();
        int lat1 = -1, lat15 = -1, n1 = 0, n15 = 0;
        logic [15:0] r1 = '0, r15 = '0;
        logic [15:0] want = 16'h1234 ^ 16'h5555;
        @(negedge clk);
        f1_req = 1; f15_req = 1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (f1_ack) begin
                n1++;
                if (lat1 < 0) begin lat1 = n; r1 = f1_rdata; f1_req = 0; end
            end
            if (f15_ack) begin
                n15++;
                if (lat15 < 0) begin lat15 = n; r15 = f15_rdata; f15_req = 0; end
            end
        end
        f1_req = 0; f15_req = 0;
        checks++;
        if (lat1 !== 2) $display("FAIL lat1: got %0d want 2", lat1);
        else passed++;
        checks++;
        if (lat15 !== 16) $display("FAIL lat15: got %0d want 16", lat15);
        else passed++;
        checks++;
        if (r1 !== want || r15 !== want)
            $display("FAIL lat_rdata: got %h/%h want %h", r1, r15, want);
        else passed++;
        checks++;
        if (n1 !== 1 || n15 !== 1)
            $display("FAIL lat_pulses: got %0d/%0d want 1/1", n1, n15);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_single_fetch();
        test_contention();
        test_back_to_back();
        test_input_churn();
        test_reset_mid();
        test_latency();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Arbitrates the LC3 single-port memory bus between two requesters: the instruction-fetch unit (F port) and the load/store data unit (D port).
Sequences each access onto the bus signals (mem_en, mem_rw, mem_addr, mem_din, mem_dout) with a fixed memory latency.
Returns read data to the winner with a one-cycle acknowledge.
Sits between the LC3 control FSM/datapath and the memory model.

Parameters:
MEM_LAT, 2, number of cycles mem_en/mem_addr are held per access (range 1..15).
AW, 16, address width.
DW, 16, data width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
f_req  in  1  fetch request (always a read)
f_addr  in  AW  fetch address (PC)
f_ack  out  1  one-cycle pulse: fetch complete, f_rdata valid
f_rdata  out  DW  fetched instruction
d_req  in  1  data request
d_rw  in  1  1 = write, 0 = read
d_addr  in  AW  data address (MAR)
d_wdata  in  DW  write data (MDR)
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  DW  read data
mem_en  out  1  memory access active
mem_rw  out  1  1 = write
mem_addr  out  AW  memory address
mem_din  out  DW  data to memory
mem_dout  in  DW  data from memory
busy  out  1  high when state is not IDLE

Behaviour:
- Reset:
  - State goes to IDLE.
  - mem_en, mem_rw, f_ack, d_ack, busy are 0.
  - mem_addr, mem_din, f_rdata, d_rdata are 0.
  - Latency counter is 0; last_grant = F.
  - A reset during ACCESS aborts the access; no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample requests each cycle.
  - Default priority: D over F.
  - On a grant, latch the winner, its address, rw (F forces rw=0) and wdata into registers.
  - Then move to ACCESS and load the counter with MEM_LAT-1.
- ACCESS:
  - mem_en = 1; mem_rw/mem_addr/mem_din come from the latched registers and stay stable for exactly MEM_LAT cycles.
  - The counter decrements each cycle; at 0, capture mem_dout into the winner's rdata register (reads only) and move to RESP.
  - A write leaves the rdata registers unchanged.
- RESP:
  - mem_en = 0.
  - The winner's ack is high for exactly this one cycle; go to IDLE next.
  - Requests are not arbitrated in RESP.
- Latency: a request first seen in IDLE at edge k gives ACCESS for cycles k+1..k+MEM_LAT and ack in cycle k+MEM_LAT+1.
  - Back-to-back service period is MEM_LAT+2 cycles.
- Requester rules:
  - Hold req, addr, rw and wdata stable until ack.
  - Deassert req in the cycle after ack, or keep it high to request another access.
  - The arbiter uses only its latched copies after the grant, so input changes during ACCESS have no effect.
- Simultaneous f_req and d_req in IDLE: D wins; F stays pending and is served in the next IDLE.
- req deasserted before ack: the access still completes and ack still pulses.
- Address wrap: none. Addresses pass through unmodified; 16'hFFFF is legal.
- rdata registers hold their value until the next read completes for that port.
- last_grant updates on every grant.

Optional Feature:
- Macro: LC3_ARB_RR_EN.
- Defined: when both requesters are pending in IDLE, the grant goes to the port opposite last_grant (round-robin). This bounds F's wait to one D access.
- Undefined: fixed priority D over F; last_grant is still maintained but not used for decisions.

Decomposition:
- Shared package lc3_mem_pkg:
  - state typedef {IDLE, ACCESS, RESP}
  - port-id typedef {PORT_F, PORT_D}
  - constants MEM_RD = 0, MEM_WR = 1, default LC3_MEM_LAT = 2
- One natural sub-module: lc3_arb_pick. It is combinational: inputs f_req, d_req, last_grant; outputs grant_valid, grant_id. The macro is confined to it.

Test Plan:
- Single fetch: reset, then f_req=1, f_addr=16'h3000, memory holds 16'h1261 → mem_en high for 2 cycles at addr 3000, rw=0; f_ack pulses in cycle 3 after the request edge; f_rdata=16'h1261; d_ack stays 0.
- Data write: d_req=1, d_rw=1, d_addr=16'h4005, d_wdata=16'hBEEF → mem_rw=1, mem_din=BEEF for 2 cycles; d_ack pulses once; memory[4005]=BEEF; d_rdata unchanged.
- Contention: f_req and d_req asserted together (d read of 16'h4000) → D served first, then F. Without LC3_ARB_RR_EN, with d_req held continuously, F never wins. With the macro, grants alternate D, F, D, F.
- Input churn: change d_addr to 16'h0000 during ACCESS → mem_addr keeps the latched 16'h4000.
- Reset mid-access: assert rst in the 2nd ACCESS cycle → next cycle mem_en=0, busy=0, no ack; a fresh request afterwards completes normally.
- MEM_LAT=1 and MEM_LAT=15 builds: measure ack latency = MEM_LAT+1 cycles for both.
